// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: A-accumulator micro-op sequencer for the 65C02 core.
// Optional macro ACC_SEQ_DECIMAL_CYCLE_EN adds the BCD extra ALU cycle.
module accumulator_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  output logic       op_ready,
  input  logic       decimal_mode,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [7:0] acc_value,
  output logic       instruction_decode_in,
  output logic       alu_to_accumulator_xfer,
  output logic       a_increment,
  output logic       a_decrement,
  output logic       nz_update,
  output logic       n_flag,
  output logic       z_flag,
  output logic       op_done,
  output logic       op_error
);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_INC      = 3'd2;
  localparam logic [2:0] OP_DEC      = 3'd3;
  localparam logic [2:0] OP_ALU_WB   = 3'd4;
  localparam logic [2:0] OP_ALU_NOWB = 3'd5;

  localparam logic [7:0] LIMIT = ALU_TIMEOUT[7:0];

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    ALU_WAIT,
`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
    DEC_FIX,
`endif
    WRITE,
    FLAGS
  } state_t;

  state_t     state_q;
  state_t     alu_next_d;
  logic [7:0] cnt_q;
  logic       wb_q;

`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
  logic       dec_q;
`else
  logic       unused_dec;
  assign unused_dec = decimal_mode;
`endif

  // Where an ALU op goes once its result is valid
  always_comb begin
    alu_next_d = wb_q ? WRITE : FLAGS;
`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
    if (dec_q) alu_next_d = DEC_FIX;
`endif
  end

  // Sequencer state machine with registered strobes and pulses
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q                 <= IDLE;
      cnt_q                   <= '0;
      wb_q                    <= 1'b0;
`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
      dec_q                   <= 1'b0;
`endif
      op_ready                <= 1'b1;
      alu_start               <= 1'b0;
      instruction_decode_in   <= 1'b0;
      alu_to_accumulator_xfer <= 1'b0;
      a_increment             <= 1'b0;
      a_decrement             <= 1'b0;
      nz_update               <= 1'b0;
      n_flag                  <= 1'b0;
      z_flag                  <= 1'b0;
      op_done                 <= 1'b0;
      op_error                <= 1'b0;
    end else begin
      alu_start               <= 1'b0;
      instruction_decode_in   <= 1'b0;
      alu_to_accumulator_xfer <= 1'b0;
      a_increment             <= 1'b0;
      a_decrement             <= 1'b0;
      nz_update               <= 1'b0;
      op_done                 <= 1'b0;
      op_error                <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_NOP: op_done <= 1'b1;
              OP_LOAD, OP_INC, OP_DEC: begin
                instruction_decode_in <= (op_code == OP_LOAD);
                a_increment           <= (op_code == OP_INC);
                a_decrement           <= (op_code == OP_DEC);
                wb_q                  <= 1'b1;
                op_ready              <= 1'b0;
                state_q               <= STROBE;
              end
              OP_ALU_WB, OP_ALU_NOWB: begin
                alu_start <= 1'b1;
                cnt_q     <= 8'd1;
                wb_q      <= (op_code == OP_ALU_WB);
`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
                dec_q     <= decimal_mode;
`endif
                op_ready  <= 1'b0;
                state_q   <= ALU_WAIT;
              end
              default: op_error <= 1'b1;
            endcase
          end
        end
        STROBE: state_q <= FLAGS;
        ALU_WAIT: begin
          if (alu_done) begin
            state_q                 <= alu_next_d;
            alu_to_accumulator_xfer <= (alu_next_d == WRITE);
            cnt_q                   <= '0;
          end else if (cnt_q >= LIMIT) begin
            op_error <= 1'b1;
            op_ready <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
        DEC_FIX: begin
          state_q                 <= wb_q ? WRITE : FLAGS;
          alu_to_accumulator_xfer <= wb_q;
        end
`endif
        WRITE: state_q <= FLAGS;
        FLAGS: begin
          if (wb_q) begin
            n_flag    <= acc_value[7];
            z_flag    <= (acc_value == 8'h00);
            nz_update <= 1'b1;
          end
          op_done  <= 1'b1;
          op_ready <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb_accumulator_sequencer: directed bench for accumulator_sequencer.
// Expected latencies follow ACC_SEQ_DECIMAL_CYCLE_EN when defined.
module tb_accumulator_sequencer;

  logic       fclk = 1'b0;
  logic       resb;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       decimal_mode;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] acc_value;
  logic       instruction_decode_in;
  logic       alu_to_accumulator_xfer;
  logic       a_increment;
  logic       a_decrement;
  logic       nz_update;
  logic       n_flag;
  logic       z_flag;
  logic       op_done;
  logic       op_error;

  int n_pass = 0;
  int n_total = 0;

`ifdef ACC_SEQ_DECIMAL_CYCLE_EN
  localparam int XD = 6;
`else
  localparam int XD = 5;
`endif

  accumulator_sequencer #(.ALU_TIMEOUT(15)) dut (
    .fclk                    (fclk),
    .resb                    (resb),
    .op_valid                (op_valid),
    .op_code                 (op_code),
    .op_ready                (op_ready),
    .decimal_mode            (decimal_mode),
    .alu_start               (alu_start),
    .alu_done                (alu_done),
    .acc_value               (acc_value),
    .instruction_decode_in   (instruction_decode_in),
    .alu_to_accumulator_xfer (alu_to_accumulator_xfer),
    .a_increment             (a_increment),
    .a_decrement             (a_decrement),
    .nz_update               (nz_update),
    .n_flag                  (n_flag),
    .z_flag                  (z_flag),
    .op_done                 (op_done),
    .op_error                (op_error)
  );

  always #5 fclk = ~fclk;

  wire [3:0] strb = {instruction_decode_in,
                     alu_to_accumulator_xfer,
                     a_increment, a_decrement};
  wire [9:0] outs = {alu_start, strb, nz_update,
                     n_flag, z_flag, op_done, op_error};

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Runs one ALU op and records what happened, cycle 1 = T1
  task automatic alu_run(
    input  logic [2:0] code,
    input  logic       dm,
    input  int         done_at,
    input  logic [7:0] acc,
    output int         start_n,
    output int         xfer_cyc,
    output int         xfer_n,
    output int         nz_n,
    output int         done_cyc,
    output int         err_cyc,
    output logic       rdy_after,
    output logic       rdy_before,
    output logic       n_seen
  );
    start_n = 0; xfer_cyc = 0; xfer_n = 0;
    nz_n = 0; done_cyc = 0; err_cyc = 0;
    rdy_after = 1'bx; rdy_before = 1'bx;
    n_seen = 1'bx;
    op_valid = 1'b1; op_code = code;
    decimal_mode = dm; acc_value = acc;
    alu_done = 1'b0;
    tick();
    op_valid = 1'b0; op_code = 3'd0;
    decimal_mode = ~dm;
    for (int c = 1; c <= 30; c++) begin
      alu_done = (c == done_at);
      if (alu_start) start_n++;
      if (alu_to_accumulator_xfer) begin
        xfer_n++;
        if (xfer_cyc == 0) xfer_cyc = c;
      end
      if (nz_update) begin
        nz_n++;
        n_seen = n_flag;
      end
      if (op_done && done_cyc == 0) done_cyc = c;
      if (op_error && err_cyc == 0) begin
        err_cyc = c;
        rdy_after = op_ready;
      end
      if (c == 15) rdy_before = op_ready;
      tick();
    end
    alu_done = 1'b0;
  endtask

  task automatic test_reset();
    resb = 1'b0;
    repeat (3) tick();
    n_total++;
    if (op_ready !== 1'b1)
      $display("FAIL rst_ready got %b exp 1", op_ready);
    else n_pass++;
    n_total++;
    if (outs !== 10'd0)
      $display("FAIL rst_outs got %h exp 000", outs);
    else n_pass++;
    resb = 1'b1;
    tick();
    n_total++;
    if (outs !== 10'd0 || op_ready !== 1'b1)
      $display("FAIL idle_outs got %h/%b exp 000/1",
               outs, op_ready);
    else n_pass++;
  endtask

  task automatic test_load();
    op_valid = 1'b1; op_code = 3'd1;
    acc_value = 8'hAA;
    tick();
    op_valid = 1'b0;
    n_total++;
    if (strb !== 4'b1000 || op_ready !== 1'b0)
      $display("FAIL load_t1 got %b/%b exp 1000/0",
               strb, op_ready);
    else n_pass++;
    acc_value = 8'h00;
    tick();
    n_total++;
    if (strb !== 4'b0000 || nz_update !== 1'b0)
      $display("FAIL load_t2 got %b/%b exp 0000/0",
               strb, nz_update);
    else n_pass++;
    tick();
    n_total++;
    if ({nz_update, z_flag, n_flag, op_done, op_ready}
        !== 5'b11011)
      $display("FAIL load_t3 got %b exp 11011",
               {nz_update, z_flag, n_flag, op_done, op_ready});
    else n_pass++;
    tick();
    n_total++;
    if (nz_update !== 1'b0 || op_done !== 1'b0)
      $display("FAIL load_t4 got %b%b exp 00",
               nz_update, op_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    op_valid = 1'b1; op_code = 3'd2;
    acc_value = 8'h7F;
    tick();
    n_total++;
    if (strb !== 4'b0010)
      $display("FAIL inc_t1 got %b exp 0010", strb);
    else n_pass++;
    acc_value = 8'h80;
    op_code = 3'd3;
    tick();
    n_total++;
    if (op_ready !== 1'b0 || strb !== 4'b0000)
      $display("FAIL inc_t2 got %b/%b exp 0/0000",
               op_ready, strb);
    else n_pass++;
    tick();
    n_total++;
    if ({nz_update, n_flag, z_flag, op_ready}
        !== 4'b1101)
      $display("FAIL inc_t3 got %b exp 1101",
               {nz_update, n_flag, z_flag, op_ready});
    else n_pass++;
    tick();
    n_total++;
    if (strb !== 4'b0001 || op_ready !== 1'b0)
      $display("FAIL dec_accept got %b/%b exp 0001/0",
               strb, op_ready);
    else n_pass++;
    op_valid = 1'b0;
    acc_value = 8'h7F;
    tick();
    tick();
    n_total++;
    if ({nz_update, n_flag, z_flag, op_done}
        !== 4'b1001)
      $display("FAIL dec_t3 got %b exp 1001",
               {nz_update, n_flag, z_flag, op_done});
    else n_pass++;
    tick();
  endtask

  task automatic test_alu();
    int s, xc, xn, nz, dc, ec;
    logic ra, rb, ns;
    alu_run(3'd4, 1'b1, 4, 8'h85,
            s, xc, xn, nz, dc, ec, ra, rb, ns);
    n_total++;
    if (s != 1 || xc != XD || xn != 1)
      $display("FAIL alu_wb_dec got s%0d x%0d n%0d exp s1 x%0d n1",
               s, xc, xn, XD);
    else n_pass++;
    n_total++;
    if (nz != 1 || dc != XD + 2 || ns !== 1'b1 || ec != 0)
      $display("FAIL alu_wb_flags got nz%0d d%0d n%b e%0d exp nz1 d%0d n1 e0",
               nz, dc, ns, ec, XD + 2);
    else n_pass++;
    alu_run(3'd4, 1'b0, 4, 8'h00,
            s, xc, xn, nz, dc, ec, ra, rb, ns);
    n_total++;
    if (xc != 5 || dc != 7)
      $display("FAIL alu_wb_bin got x%0d d%0d exp x5 d7", xc, dc);
    else n_pass++;
    alu_run(3'd5, 1'b1, 4, 8'h00,
            s, xc, xn, nz, dc, ec, ra, rb, ns);
    n_total++;
    if (xn != 0 || nz != 0 || dc != XD + 1)
      $display("FAIL alu_nowb got x%0d nz%0d d%0d exp x0 nz0 d%0d",
               xn, nz, dc, XD + 1);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int s, xc, xn, nz, dc, ec;
    logic ra, rb, ns;
    alu_run(3'd4, 1'b0, 0, 8'h00,
            s, xc, xn, nz, dc, ec, ra, rb, ns);
    n_total++;
    if (ec != 16 || xn != 0 || dc != 0)
      $display("FAIL timeout got e%0d x%0d d%0d exp e16 x0 d0",
               ec, xn, dc);
    else n_pass++;
    n_total++;
    if (ra !== 1'b1 || rb !== 1'b0)
      $display("FAIL timeout_ready got %b%b exp 10", ra, rb);
    else n_pass++;
    alu_run(3'd4, 1'b0, 15, 8'h00,
            s, xc, xn, nz, dc, ec, ra, rb, ns);
    n_total++;
    if (ec != 0 || xc != 16 || dc != 18)
      $display("FAIL limit_done got e%0d x%0d d%0d exp e0 x16 d18",
               ec, xc, dc);
    else n_pass++;
  endtask

  task automatic test_illegal();
    for (int k = 6; k <= 7; k++) begin
      op_valid = 1'b1; op_code = 3'(k);
      tick();
      op_valid = 1'b0;
      n_total++;
      if ({op_error, op_done, op_ready, strb}
          !== 7'b1010000)
        $display("FAIL illegal_%0d got %b exp 1010000",
                 k, {op_error, op_done, op_ready, strb});
      else n_pass++;
      tick();
      n_total++;
      if (op_error !== 1'b0)
        $display("FAIL illegal_pulse_%0d got %b exp 0",
                 k, op_error);
      else n_pass++;
    end
    op_valid = 1'b1; op_code = 3'd0;
    tick();
    op_valid = 1'b0;
    n_total++;
    if ({op_done, op_error, op_ready, strb}
        !== 7'b1010000)
      $display("FAIL nop got %b exp 1010000",
               {op_done, op_error, op_ready, strb});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op_code = 3'd4;
    decimal_mode = 1'b0; alu_done = 1'b0;
    tick();
    op_valid = 1'b0;
    n_total++;
    if (alu_start !== 1'b1)
      $display("FAIL mid_start got %b exp 1", alu_start);
    else n_pass++;
    resb = 1'b0;
    #1;
    n_total++;
    if (outs !== 10'd0 || op_ready !== 1'b1)
      $display("FAIL mid_reset got %h/%b exp 000/1",
               outs, op_ready);
    else n_pass++;
    tick();
    tick();
    resb = 1'b1;
    alu_done = 1'b1;
    op_valid = 1'b1; op_code = 3'd1;
    tick();
    op_valid = 1'b0;
    n_total++;
    if (strb !== 4'b1000)
      $display("FAIL post_reset_accept got %b exp 1000", strb);
    else n_pass++;
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_total++;
      if (alu_to_accumulator_xfer !== 1'b0 ||
          op_error !== 1'b0)
        $display("FAIL late_done_%0d got %b%b exp 00", c,
                 alu_to_accumulator_xfer, op_error);
      else n_pass++;
    end
    alu_done = 1'b0;
  endtask

  initial begin
    resb = 1'b0; op_valid = 1'b0; op_code = 3'd0;
    decimal_mode = 1'b0; alu_done = 1'b0;
    acc_value = 8'h00;
    test_reset();
    test_load();
    test_back_to_back();
    test_alu();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
